mux_rr_arbiter: RTL and testbench

- 8-way round-robin arbiter and sequencer for the one-hot-select 8:1 data mux.
- Eight requesters compete for a single shared output channel. The block picks one winner per beat and drives a one-hot select to steer that requester's data.
- Supports multi-beat bursts: the grant is locked to one owner until it presents its last beat.
- Output is a single registered stage with a valid/ready handshake toward the downstream consumer.

---
 rtl/mux_rr_arbiter.sv | 88 ++++++++
 tb/tb_mux_rr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// 8-way round-robin arbiter driving a one-hot-select 8:1 data mux, with burst
// locking and a single registered output stage using a valid/ready handshake.
module mux_rr_arbiter #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [7:0]      req,
  input  logic [7:0]      last,
  input  logic [8*DW-1:0] in,
  output logic [7:0]      ack,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [7:0]      out_sel,
  output logic            out_last,
  output logic            busy
);

  // Handshake: a beat moves downstream on any edge where out_valid && out_ready;
  // requester c's beat is taken on any edge where ack[c] is high.
  localparam logic IDLE   = 1'b0;
  localparam logic LOCKED = 1'b1;

  logic       state;
  logic [2:0] ptr;
  logic [2:0] owner;
  logic [2:0] cand;
  logic [2:0] idx;
  logic       cand_vld;
  logic       load;
  logic       accept;

  // Scan from the far end back toward ptr so the closest requester wins.
  always_comb begin
    cand     = 3'd0;
    cand_vld = 1'b0;
    idx      = 3'd0;
    if (state == LOCKED) begin
      cand     = owner;
      cand_vld = req[owner];
    end else begin
      for (int k = 7; k >= 0; k--) begin
        idx = ptr + 3'(k);
        if (req[idx]) begin
          cand     = idx;
          cand_vld = 1'b1;
        end
      end
    end
  end

  assign load   = ~out_valid | out_ready;
  assign accept = load & cand_vld;
  assign ack    = (accept && nreset) ? (8'b1 << cand) : 8'h00;
  assign busy   = (state == LOCKED);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 8'h00;
      out_last  <= 1'b0;
      state     <= IDLE;
      ptr       <= 3'd0;
      owner     <= 3'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in[DW*cand +: DW];
      out_sel   <= 8'b1 << cand;
      out_last  <= last[cand];
      if (state == IDLE) begin
        if (last[cand]) begin
          ptr <= cand + 3'd1;
        end else begin
          state <= LOCKED;
          owner <= cand;
        end
      end else if (last[cand]) begin
        state <= IDLE;
        ptr   <= owner + 3'd1;
      end
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed vector table plus a randomized scoreboard run for mux_rr_arbiter.
module tb_mux_rr_arbiter;

  logic        clk;
  logic        nreset;
  logic [7:0]  req;
  logic [7:0]  last;
  logic [63:0] in_bus;
  logic [7:0]  ack;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [7:0]  out_sel;
  logic        out_last;
  logic        busy;

  mux_rr_arbiter #(.DW(8)) dut (
    .clk(clk), .nreset(nreset), .req(req), .last(last), .in(in_bus),
    .ack(ack), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .out_last(out_last), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] last;
    logic       rdy;
    logic [7:0] ack;
    logic       ov;
    logic [7:0] sel;
    logic       ol;
    logic       busy;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          n_checks;
  int          n_fail;
  int          wait_cnt[8];
  logic [7:0]  ack_q;
  logic [7:0]  rq_r;
  logic [7:0]  lst_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic add(input logic rst, input logic [7:0] rq, input logic [7:0] lst,
                     input logic rdy, input logic [7:0] a, input logic ov,
                     input logic [7:0] sel, input logic ol, input logic bsy);
    vec_t v;
    v.rst = rst; v.req = rq; v.last = lst; v.rdy = rdy; v.ack = a;
    v.ov = ov; v.sel = sel; v.ol = ol; v.busy = bsy;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 8'h00;
    nreset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  // driver: one vector per cycle, inputs at negedge, outputs checked 1ns later
  task automatic apply_vectors();
    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      @(negedge clk);
      req       = vecs[k].req;
      last      = vecs[k].last;
      out_ready = vecs[k].rdy;
      #1;
      check($sformatf("v%0d ack", k), 32'(ack), 32'(vecs[k].ack));
      check($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(vecs[k].ov));
      check($sformatf("v%0d busy", k), 32'(busy), 32'(vecs[k].busy));
      if (vecs[k].ov) begin
        check($sformatf("v%0d out_sel", k), 32'(out_sel), 32'(vecs[k].sel));
        check($sformatf("v%0d out_last", k), 32'(out_last), 32'(vecs[k].ol));
        check($sformatf("v%0d out_data", k), 32'(out_data), 32'(8'hA0 + 8'(oh_idx(vecs[k].sel))));
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    nreset    = 1'b0;
    req       = 8'h00;
    last      = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_bus[8*i +: 8] = 8'hA0 + 8'(i);

    // Mid-burst reset: lock requester 0, then pull reset.
    do_reset();
    @(negedge clk);
    req = 8'hFF; last = 8'h00; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("pre-reset busy", 32'(busy), 32'd1);
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    nreset = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_sel", 32'(out_sel), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst out_last", 32'(out_last), 32'd0);
    check("rst ack", 32'(ack), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("rst ack held", 32'(ack), 32'd0);
    req = 8'h00;
    nreset = 1'b1;

    // Rotation 0..7,0,1 with all requesting single beats.
    for (int k = 0; k < 10; k++)
      add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'(1 << (k % 8)), k > 0, 8'(1 << ((k + 7) % 8)), 1'b1, 1'b0);

    // Round-robin skip over 2, 5, 7.
    add(1'b1, 8'hA4, 8'hFF, 1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 8'hA4, 8'hFF, 1'b1, 8'h20, 1'b1, 8'h04, 1'b1, 1'b0);
    add(1'b0, 8'hA4, 8'hFF, 1'b1, 8'h80, 1'b1, 8'h20, 1'b1, 1'b0);
    add(1'b0, 8'hA4, 8'hFF, 1'b1, 8'h04, 1'b1, 8'h80, 1'b1, 1'b0);
    add(1'b0, 8'hA4, 8'hFF, 1'b1, 8'h20, 1'b1, 8'h04, 1'b1, 1'b0);

    // Burst lock on requester 3 (four beats).
    add(1'b1, 8'hFF, 8'hFF, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h02, 1'b1, 8'h01, 1'b1, 1'b0);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h04, 1'b1, 8'h02, 1'b1, 1'b0);
    add(1'b0, 8'hFF, 8'hF7, 1'b1, 8'h08, 1'b1, 8'h04, 1'b1, 1'b0);
    add(1'b0, 8'hFF, 8'hF7, 1'b1, 8'h08, 1'b1, 8'h08, 1'b0, 1'b1);
    add(1'b0, 8'hFF, 8'hF7, 1'b1, 8'h08, 1'b1, 8'h08, 1'b0, 1'b1);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h08, 1'b1, 8'h08, 1'b0, 1'b1);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h10, 1'b1, 8'h08, 1'b1, 1'b0);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h20, 1'b1, 8'h10, 1'b1, 1'b0);

    // Backpressure: empty register still loads, full register stalls 5 cycles.
    add(1'b1, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 8'hFF, 8'hFF, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      add(1'b0, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h02, 1'b1, 8'h01, 1'b1, 1'b0);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h04, 1'b1, 8'h02, 1'b1, 1'b0);

    // Owner stall on requester 6 while requester 1 waits.
    add(1'b1, 8'h40, 8'h00, 1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 8'h02, 8'h00, 1'b1, 8'h00, 1'b1, 8'h40, 1'b0, 1'b1);
    add(1'b0, 8'h02, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    add(1'b0, 8'h02, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    add(1'b0, 8'h42, 8'h40, 1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 1'b1);
    add(1'b0, 8'h02, 8'hFF, 1'b1, 8'h02, 1'b1, 8'h40, 1'b1, 1'b0);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 8'h02, 1'b1, 1'b0);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    apply_vectors();

    // Random traffic with a scoreboard and a fairness bound.
    do_reset();
    rq_r  = 8'h00;
    lst_r = 8'h00;
    ack_q = 8'h00;
    for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (ack_q[i]) begin
          rq_r[i]  = ($urandom_range(0, 2) != 0);
          lst_r[i] = 1'($urandom_range(0, 1));
        end else if (!rq_r[i]) begin
          rq_r[i]  = ($urandom_range(0, 3) == 0);
          lst_r[i] = 1'($urandom_range(0, 1));
        end
      end
      req       = rq_r;
      last      = lst_r;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("sb unexpected beat", 32'({out_sel, out_data}), 32'hFFFF_FFFF);
        end else begin
          check("sb beat", 32'({out_sel, out_data}), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
        if (!out_ready) check("stall ack", 32'(ack), 32'd0);
      end else begin
        check("sb idle", 32'(exp_q.size()), 32'd0);
      end
      check("ack onehot", 32'($countones(ack) <= 1), 32'd1);
      if (ack != 8'h00) begin
        automatic int c = oh_idx(ack);
        exp_q.push_back({ack, 8'hA0 + 8'(c)});
        wait_cnt[c] = 0;
        if (last[c]) begin
          for (int j = 0; j < 8; j++) begin
            if (j != c && rq_r[j]) begin
              wait_cnt[j]++;
              check($sformatf("fairness req%0d", j), 32'(wait_cnt[j] <= 7), 32'd1);
            end
          end
        end
      end
      ack_q = ack;
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
